// File: rtl/param_fifo_loop.sv
// Self-checking FIFO loopback: pattern writer, synchronous FIFO and reader/checker.
// Runs fill/drain passes or continuous streaming between the two thresholds.
module param_fifo_loop #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    output logic [DATA_W-1:0] q,
    output logic              q_vld,
    output logic [ADDR_W:0]   usedw,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              err,
    output logic [15:0]       pass_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] U_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] U_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] U_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] U_AF = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] U_AE = (ADDR_W + 1)'(AE_LVL);
    localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        STREAM
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] wdat_q, exp_q, q_q;
    logic              vld_q, err_q;
    logic [15:0]       pass_q, pass_d;
    logic              wrreq, rdreq, wr_en, rd_en, mism;

    assign usedw        = wr_ptr_q - rd_ptr_q;
    assign full         = (usedw == U_FULL);
    assign empty        = (usedw == '0);
    assign almost_full  = (usedw >= U_AF);
    assign almost_empty = (usedw <= U_AE);

    // Flag a bad word in the same cycle it is presented, then hold it
    assign mism     = vld_q && (q_q != exp_q);
    assign err      = err_q | mism;
    assign q        = q_q;
    assign q_vld    = vld_q;
    assign pass_cnt = pass_q;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        unique case (state_q)
            FILL:    wrreq = en;
            DRAIN:   rdreq = en;
            STREAM: begin
                wrreq = en && (usedw < U_AF);
                rdreq = en && (usedw > U_AE);
            end
            default: ;
        endcase
        wr_en = wrreq && !full;
        rd_en = rdreq && !empty;
        unique case (state_q)
            IDLE:    state_d = mode ? STREAM : FILL;
            FILL:    if (wr_en && usedw == U_LAST) state_d = DRAIN;
            DRAIN: begin
                if (rd_en && usedw == U_ONE) begin
                    state_d = FILL;
                    if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
                end
            end
            default: ;
        endcase
        if (!en) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wdat_q   <= '0;
            exp_q    <= '0;
            q_q      <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            pass_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            vld_q   <= rd_en;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + U_ONE;
                wdat_q   <= wdat_q + D_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + U_ONE;
                q_q      <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            end
            if (vld_q) begin
                exp_q <= exp_q + D_ONE;
                if (mism) err_q <= 1'b1;
            end
        end
    end
endmodule
